// File: rtl/div_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_iter_pkg                                                 |
// | Description : Shared op/state encodings and default width for div_iter.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package div_iter_pkg;

    localparam int c_NUM_DEFAULT = 32;

    typedef logic [1:0] op_t;
    localparam op_t c_OP_DIV  = 2'b00;
    localparam op_t c_OP_DIVU = 2'b01;
    localparam op_t c_OP_REM  = 2'b10;
    localparam op_t c_OP_REMU = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_CALC = 2'd1;
    localparam state_t c_ST_FIX  = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_iter_if                                                  |
// | Description : Request/response handshake bundle for the iterative divider. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface div_iter_if
    import div_iter_pkg::*;
#(
    parameter int NUM = c_NUM_DEFAULT
) ();

    logic           in_valid;
    logic           in_ready;
    op_t            op;
    logic [NUM-1:0] dividend;
    logic [NUM-1:0] divisor;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [NUM-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface : div_iter_if
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cla_adder                                                    |
// | Description : Parallel-prefix adder; "hybird" = Sklansky, else Brent-Kung. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cla_adder #(
    parameter int WIDTH = 33,
    parameter     ST    = "hybird"
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int c_TOP = 1 << ($clog2(WIDTH) - 1);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_gin;
    logic [WIDTH-1:0] w_pref;
    logic [WIDTH-1:0] w_c;

    function automatic logic [WIDTH-1:0] prefix_sklansky(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        int               j;
        g = g_in;
        p = p_in;
        for (int lvl = 0; (1 << lvl) < WIDTH; lvl++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (((i >> lvl) & 1) == 1) begin
                    j    = ((i >> lvl) << lvl) - 1;
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] prefix_brent_kung(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int d = 1; d < WIDTH; d = d * 2) begin
            for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        // Down-sweep fills the gaps left between the power-of-two spans.
        for (int d = c_TOP; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        return g;
    endfunction

    assign w_g   = i_a & i_b;
    assign w_p   = i_a ^ i_b;
    assign w_gin = {w_g[WIDTH-1:1], w_g[0] | (w_p[0] & i_cin)};

    generate
        if (ST == "hybird") begin : g_sklansky
            assign w_pref = prefix_sklansky(w_gin, w_p);
        end else begin : g_brent_kung
            assign w_pref = prefix_brent_kung(w_gin, w_p);
        end
    endgenerate

    assign w_c    = {w_pref[WIDTH-2:0], i_cin};
    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_pref[WIDTH-1];

endmodule : cla_adder
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_iter                                                     |
// | Description : Radix-2 restoring divider for DIV/DIVU/REM/REMU, NUM+2 lat.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module div_iter
    import div_iter_pkg::*;
#(
    parameter int NUM = c_NUM_DEFAULT,
    parameter     ST  = "hybird"
) (
    input  logic       clk,
    input  logic       rst,
    div_iter_if.slave  bus
);

    localparam int             c_CW   = $clog2(NUM) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NUM - 1);
    localparam logic [NUM-1:0] c_MIN  = {1'b1, {(NUM-1){1'b0}}};

    state_t          r_state;
    op_t             r_op;
    logic [NUM-1:0]  r_quo;
    logic [NUM-1:0]  r_rem;
    logic [NUM:0]    r_neg_dvs;
    logic            r_qsign;
    logic            r_rsign;
    logic [c_CW-1:0] r_cnt;
    logic [NUM-1:0]  r_result;
    logic            r_out_valid;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_signed;
    logic           w_dvd_neg;
    logic           w_dvs_neg;
    logic [NUM-1:0] w_dvd_abs;
    logic [NUM-1:0] w_dvs_abs;
    logic [NUM:0]   w_neg_dvs;
    logic           w_dvs_zero;
    logic           w_ovf;
    logic [NUM-1:0] w_special_res;
    logic [NUM:0]   w_shift;
    logic [NUM:0]   w_trial;
    logic           w_carry;
    logic [NUM:0]   w_rem_full;
    logic           w_unused_rem_msb;
    logic [NUM-1:0] w_quo_fix;
    logic [NUM-1:0] w_rem_fix;
    logic [NUM-1:0] w_fix_res;

    assign w_in_ready = (r_state == c_ST_IDLE) && !rst;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    // op[0] set means unsigned for both the divide and remainder encodings.
    assign w_signed   = ~bus.op[0];
    assign w_dvd_neg  = w_signed & bus.dividend[NUM-1];
    assign w_dvs_neg  = w_signed & bus.divisor[NUM-1];
    assign w_dvd_abs  = w_dvd_neg ? (~bus.dividend + NUM'(1)) : bus.dividend;
    assign w_dvs_abs  = w_dvs_neg ? (~bus.divisor + NUM'(1)) : bus.divisor;
    assign w_neg_dvs  = ~{1'b0, w_dvs_abs} + (NUM+1)'(1);

    assign w_dvs_zero = (bus.divisor == '0);
    assign w_ovf      = w_signed && (bus.dividend == c_MIN) && (bus.divisor == '1);

    always_comb begin
        w_special_res = '0;
        if (w_dvs_zero) begin
            w_special_res = bus.op[1] ? bus.dividend : '1;
        end else begin
            w_special_res = bus.op[1] ? '0 : bus.dividend;
        end
    end

    assign w_shift = {r_rem, r_quo[NUM-1]};

    cla_adder #(
        .WIDTH (NUM + 1),
        .ST    (ST)
    ) u_cla (
        .i_a    (w_shift),
        .i_b    (r_neg_dvs),
        .i_cin  (1'b0),
        .o_sum  (w_trial),
        .o_cout (w_carry)
    );

    // No carry out means the shifted remainder is below the divisor: restore.
    assign w_rem_full       = w_carry ? w_trial : w_shift;
    assign w_unused_rem_msb = w_rem_full[NUM];

    assign w_quo_fix = (r_qsign & ~r_op[0]) ? (~r_quo + NUM'(1)) : r_quo;
    assign w_rem_fix = (r_rsign & ~r_op[0]) ? (~r_rem + NUM'(1)) : r_rem;
    assign w_fix_res = r_op[1] ? w_rem_fix : w_quo_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_op        <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_neg_dvs   <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.op;
                        r_quo     <= w_dvd_abs;
                        r_rem     <= '0;
                        r_neg_dvs <= w_neg_dvs;
                        r_qsign   <= w_dvd_neg ^ w_dvs_neg;
                        r_rsign   <= w_dvd_neg;
                        r_cnt     <= '0;
                        if (w_dvs_zero || w_ovf) begin
                            r_result    <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_CALC;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_quo <= {r_quo[NUM-2:0], w_carry};
                    r_rem <= w_rem_full[NUM-1:0];
                    r_cnt <= r_cnt + c_CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_result    <= w_fix_res;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_div_iter                                                  |
// | Description : Directed self-checking bench; both adder styles in parallel. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_div_iter;
    import div_iter_pkg::*;

    localparam int c_NUM = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    div_iter_if #(.NUM(c_NUM)) dif ();
    div_iter_if #(.NUM(c_NUM)) dif_bk ();

    div_iter #(.NUM(c_NUM), .ST("hybird")) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    div_iter #(.NUM(c_NUM), .ST("bk")) u_dut_bk (
        .clk (clk),
        .rst (rst),
        .bus (dif_bk)
    );

    assign dif_bk.in_valid  = dif.in_valid;
    assign dif_bk.op        = dif.op;
    assign dif_bk.dividend  = dif.dividend;
    assign dif_bk.divisor   = dif.divisor;
    assign dif_bk.flush     = dif.flush;
    assign dif_bk.out_ready = dif.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from the accept edge to the first cycle out_valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!dif.out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic start_op(input op_t op, input logic [31:0] a, input logic [31:0] b);
        dif.op       = op;
        dif.dividend = a;
        dif.divisor  = b;
        dif.in_valid = 1'b1;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        check({tag, "_rdy"}, dif.in_ready, 1);
        start_op(op, a, b);
        wait_valid(n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_res"}, dif.result, exp);
        check({tag, "_bk_vld"}, dif_bk.out_valid, 1);
        check({tag, "_bk_res"}, dif_bk.result, exp);
        dif.out_ready = 1'b1;
        tick();
        dif.out_ready = 1'b0;
        check({tag, "_idle"}, dif.in_ready, 1);
    endtask

    initial begin
        int n;
        int hi;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.op        = c_OP_DIV;
        dif.dividend  = '0;
        dif.divisor   = '0;
        dif.flush     = 1'b0;
        dif.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_in_ready", dif.in_ready, 0);
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_result", dif.result, 0);
        rst = 1'b0;
        #1;
        check("rst_release_rdy", dif.in_ready, 1);

        run_op("divu_100_7", c_OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", c_OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("rem_m7_2", c_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("div_m7_2", c_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("divu_5_0", c_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_5_0", c_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div_ovf", c_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", c_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("div_100_m7", c_OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        run_op("rem_m100_7", c_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
        run_op("divu_max_1", c_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_op("div_min_2", c_OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);
        run_op("divu_min_max", c_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_op("remu_min_max", c_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run_op("div_m5_0", c_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_m5_0", c_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

        // Back-pressure: result must hold while the consumer stalls.
        start_op(c_OP_DIVU, 32'd1000, 32'd10);
        wait_valid(n);
        check("bp_lat", n, 34);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_res", dif.result, 100);
            check("bp_vld", dif.out_valid, 1);
            check("bp_rdy", dif.in_ready, 0);
        end
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.divisor   = 32'd0;
        tick();
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b0;
        check("bp_drain_vld", dif.out_valid, 0);
        check("bp_drain_rdy", dif.in_ready, 1);
        tick();
        check("bp_no_accept_vld", dif.out_valid, 0);
        check("bp_no_accept_rdy", dif.in_ready, 1);

        // Flush in IDLE must block a simultaneous request.
        dif.flush    = 1'b1;
        dif.in_valid = 1'b1;
        dif.divisor  = 32'd0;
        tick();
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        check("flush_idle_rdy", dif.in_ready, 1);
        check("flush_idle_vld", dif.out_valid, 0);

        // Flush during CALC.
        start_op(c_OP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        check("flush_calc_busy", dif.in_ready, 0);
        dif.flush     = 1'b1;
        dif.out_ready = 1'b1;
        tick();
        dif.flush     = 1'b0;
        dif.out_ready = 1'b0;
        check("flush_calc_rdy", dif.in_ready, 1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.out_valid) hi++;
            tick();
        end
        check("flush_no_valid", hi, 0);
        run_op("post_flush", c_OP_DIVU, 32'd200, 32'd9, 32'd22, 34);

        // Reset during CALC.
        start_op(c_OP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("rst_calc_rdy_hi", dif.in_ready, 0);
        check("rst_calc_res", dif.result, 0);
        rst = 1'b0;
        #1;
        check("rst_calc_rdy", dif.in_ready, 1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.out_valid) hi++;
            tick();
        end
        check("rst_no_valid", hi, 0);
        run_op("post_rst", c_OP_REMU, 32'd200, 32'd9, 32'd2, 34);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 The block SHALL have parameter NUM, default 32, giving operand and result width in bits.
REQ-002 The block SHALL have parameter ST, default "hybird", giving the adder style passed to cla_adder ("hybird" or any other value for BK).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  the request is present.
REQ-006 The block SHALL have port in_ready  output  1  the block can accept a request.
REQ-007 The block SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 The block SHALL have port dividend  input  NUM  operand rs1.
REQ-009 The block SHALL have port divisor  input  NUM  operand rs2.
REQ-010 The block SHALL have port flush  input  1  kill the in-flight operation.
REQ-011 The block SHALL have port out_valid  output  1  result is present.
REQ-012 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 The block SHALL have port result  output  NUM  quotient or remainder per op.

Function
REQ-014 The block SHALL implement states IDLE, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE with rst low.
REQ-015 A request SHALL be accepted on a rising edge where in_valid && in_ready && !flush; op and operands SHALL be registered then.
REQ-016 On accept, signed ops SHALL register absolute values of the operands, and all ops SHALL register the quotient sign (DIV: sign(dividend) XOR sign(divisor)) and the remainder sign (sign of dividend).
REQ-017 Divisor == 0 on accept SHALL go IDLE->DONE with result = all ones for DIV/DIVU and result = dividend for REM/REMU.
REQ-018 DIV/REM with dividend = 1 followed by NUM-1 zeros and divisor = all ones SHALL go IDLE->DONE with result = dividend (DIV) or 0 (REM).
REQ-019 All other requests SHALL go IDLE->CALC and run unsigned restoring division, one quotient bit per cycle, MSB first, for exactly NUM cycles, then CALC->FIX.
REQ-020 Each CALC step SHALL compute trial = {partial_rem, next_dividend_bit} + neg_divisor through one cla_adder instance, where neg_divisor = two's complement of |divisor|, registered at accept; a carry-free trial result SHALL restore the previous value and give quotient bit 0.
REQ-021 FIX SHALL negate the quotient (DIV) or remainder (REM) when the registered sign is 1, select the output by op, and go FIX->DONE.
REQ-022 out_valid SHALL be 1 exactly in DONE; normal ops SHALL raise out_valid NUM+2 cycles after the accept edge, and special cases 1 cycle after it.
REQ-023 In DONE, result SHALL be held stable until out_valid && out_ready, which SHALL return the block to IDLE; no new request SHALL be accepted in that same cycle.
REQ-024 flush in any state SHALL force IDLE on the next edge, drop the result, and override a simultaneous in_valid or out_ready.
REQ-025 The iteration counter SHALL be ceil(log2(NUM))+1 bits wide and SHALL NOT wrap within one operation.

Reset
REQ-026 rst high SHALL force state IDLE, out_valid 0, result 0, and counter and internal registers 0 on the next edge, aborting any in-flight operation.
REQ-027 in_ready SHALL be 0 while rst is high and SHALL become 1 in the first cycle after rst is released.

Structure
REQ-028 A shared package SHALL hold the op encodings (DIV/DIVU/REM/REMU), the state encoding, and the default NUM.
REQ-029 The block SHALL instantiate exactly one cla_adder sub-module (NUM+1 bits wide, parameter ST passed through) for the trial subtraction; operand negation SHALL reuse it or use inverter plus increment logic, with no second divider datapath.

Verification
REQ-030 DIVU 100 / 7 -> result 14, out_valid at cycle NUM+2 = 34; REMU 100 % 7 -> 2.
REQ-031 REM 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF; DIV -7 / 2 -> 0xFFFFFFFD.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 % 0 -> 5, both with out_valid 1 cycle after accept.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0, both 1-cycle latency.
REQ-034 out_ready held low 5 cycles in DONE -> result stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-035 flush, then separately rst, asserted at CALC cycle 10 -> IDLE next edge, out_valid never rises, and the next request gives a correct result.
